ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch unit sitting directly upstream of the synchronous-read instruction memory (`imem`). It owns the program counter, drives the memory address every cycle, pairs each returned instruction word with its PC, and buffers fetched instructions in a 2-entry queue. The queue feeds the decode stage through a valid/ready handshake, and control flow changes arrive from execute as single-cycle redirects.

## Interface
Parameters:
- `RESET_PC`, default 32'h8000_0000: first fetch address after reset; equals the imem base.
- `FIFO_DEPTH`, default 2: output queue entries; fixed at 2 for this revision.

Ports:
- `clk` input 1: sole clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `redirect_valid` input 1: one-cycle pulse requesting a fetch from `redirect_pc`.
- `redirect_pc` input 32: redirect target.
- `imem_addr` output 32: byte address to imem; sampled by imem at every rising edge.
- `imem_data` input 32: instruction word for the address sampled at the previous edge.
- `out_valid` output 1: queue head holds an instruction.
- `out_ready` input 1: decode accepts the head this cycle.
- `out_pc` output 32: PC of head entry; 0 when empty.
- `out_instr` output 32: instruction of head entry; 0 when empty.
- `fault` output 1: misaligned-redirect fault (present only with `IFETCH_MISALIGN_CHECK_EN`).

## Operation
- State: `pc_q` holds the next fetch address. `infl_q` and `infl_pc_q` mark a request issued last cycle. The queue holds up to 2 entries, each {pc, instr}. The FSM has states BOOT, RUN and FAULT.
- BOOT: entered on reset. Lasts one cycle. No issue occurs. The FSM then moves to RUN.
- `imem_addr` (combinational) = `redirect_valid` ? aligned `redirect_pc` : `pc_q`. It is driven even when no issue occurs; an unissued response is ignored.
- Pop: occurs when `out_valid && out_ready`.
- Issue condition, in RUN only: `count + infl_q - pop < 2`, or `redirect_valid`.
- On issue: `infl_q` <= 1, `infl_pc_q` <= `imem_addr`, and `pc_q` <= `imem_addr + 4`. The addition wraps modulo 2^32.
- Response capture: if `infl_q` is set, `{infl_pc_q, imem_data}` is pushed at the end of the cycle. The credit check guarantees space.
- Simultaneous push and pop: both take effect and count is unchanged.
- Redirect behaviour:
  - The queue is flushed and the in-flight response is dropped.
  - A pop completing in the same cycle is still a valid handshake with decode.
  - The target is issued in the same cycle.
- Priority: `rst` > `redirect_valid` > normal issue/capture.

## Timing
- Reset values:
  - Registers: `pc_q`=`RESET_PC`, `infl_q`=0, count=0, state=BOOT.
  - Outputs: `out_valid`=0, `out_pc`=0, `out_instr`=0, `fault`=0, `imem_addr`=`RESET_PC`.
- Fetch latency: address issued in cycle N, imem data valid in cycle N+1, `out_valid` high in cycle N+2.
- First instruction: `rst` deasserted in cycle 0 (BOOT), issue in cycle 1, `out_valid` in cycle 3.
- Throughput: 1 instruction per cycle sustained while `out_ready`=1.
- Stall: with `out_ready`=0, issue stops once count + in-flight reaches 2. Nothing is lost or duplicated.
- Redirect: redirect in cycle N puts the target at the head in cycle N+2 (1-cycle bubble after flush).
- Redirect while the queue is full: flush wins and the new target appears at N+2.
- Reset asserted mid-stream: all state returns to reset values at the next edge, and in-flight data is discarded.

## Configuration
- `IFETCH_MISALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0]` != 0 flushes, does not issue, enters FAULT, and sets `fault`=1.
  - FAULT issues nothing and holds `fault` until a later aligned redirect (back to RUN, `fault`=0) or `rst`.
- Undefined:
  - `redirect_pc[1:0]` is forced to 0.
  - The FAULT state and `fault` port are absent.

## Structure
- `ifetch_pkg` contains:
  - `IMEM_BASE` = 32'h8000_0000.
  - `fetch_state_t` enum {BOOT, RUN, FAULT}.
  - `fetch_entry_t` struct {pc[31:0], instr[31:0]}.
- Sub-module `ifetch_fifo`: 2-entry synchronous FIFO of `fetch_entry_t` with push, pop, flush, count and head ports. Head fields read 0 when empty.

## Test plan
- Reset release with `out_ready`=1: `out_valid` rises in cycle 3; PCs 0x8000_0000, 0x8000_0004, 0x8000_0008 appear on consecutive cycles with matching `mem` words.
- `out_ready`=0 for 5 cycles mid-stream: count saturates at 2, `imem_addr` stops advancing, and on release the PCs continue with no gap or repeat.
- Redirect to 0x8000_0040 while the queue holds 2 entries: the next `out_pc` after the bubble is 0x8000_0040, followed by 0x8000_0044; no stale entries.
- Redirect in the same cycle as a pop of PC 0x8000_0010: that pop counts, and the next output PC equals the target.
- `rst` pulsed while streaming at 0x8000_0020: outputs go to reset values and the stream restarts at 0x8000_0000.
- With `IFETCH_MISALIGN_CHECK_EN`: redirect to 0x8000_0002 gives `fault`=1 and `out_valid`=0. A later redirect to 0x8000_0008 clears `fault`, and 0x8000_0008 appears 2 cycles later.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch unit: fetch FSM states and the {pc, instr} queue entry.
package ifetch_pkg;

  localparam logic [31:0] IMEM_BASE = 32'h8000_0000;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Two-entry synchronous queue of fetched {pc, instr} pairs.
// Flush empties it in one edge; the head reads all-zero while empty.
module ifetch_fifo
  import ifetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_pop;

  assign do_pop = pop && (count != 2'd0);
  assign head   = (count != 2'd0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: owns the PC, drives imem every cycle, queues {pc, instr} for decode.
// Optional IFETCH_MISALIGN_CHECK_EN adds a FAULT state and `fault` port for misaligned redirects.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = IMEM_BASE,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
`ifdef IFETCH_MISALIGN_CHECK_EN
  ,
  output logic        fault
`endif
);

  localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q;
  logic         infl_q;
  logic [31:0]  infl_pc_q;
  logic [1:0]   count;
  fetch_entry_t head;
  logic         pop;
  logic         push;
  logic         issue;
  logic         credit_ok;
  logic         misalign;

  assign imem_addr = redirect_valid ? (redirect_pc & 32'hFFFF_FFFC) : pc_q;
  assign out_valid = (count != 2'd0);
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign pop       = out_valid && out_ready;
  // Credit counts the in-flight response so a capture always finds a free slot.
  assign credit_ok = ({1'b0, count} + {2'b00, infl_q} - {2'b00, pop}) < DEPTH;
  // A redirect drops whatever response is returning this cycle.
  assign push      = infl_q && !redirect_valid;

`ifdef IFETCH_MISALIGN_CHECK_EN
  assign misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign fault    = (state_q == FAULT);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (misalign) begin
          state_d = FAULT;
        end else begin
          issue = redirect_valid || credit_ok;
        end
      end
      FAULT: begin
        if (redirect_valid && !misalign) begin
          issue   = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
    end else begin
      state_q <= state_d;
      infl_q  <= issue;
      if (issue) begin
        infl_pc_q <= imem_addr;
        pc_q      <= imem_addr + 32'd4;
      end
    end
  end

  ifetch_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ('{pc: infl_pc_q, instr: imem_data}),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: expected PCs queued at stimulus time, checked by a negedge monitor.
module tb_ifetch;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef IFETCH_MISALIGN_CHECK_EN
  logic        fault;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  ifetch dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
`ifdef IFETCH_MISALIGN_CHECK_EN
    ,
    .fault          (fault)
`endif
  );

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  always @(posedge clk) imem_data <= mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_run(input logic [31:0] first, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(first + 32'(4 * k));
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pop: got pc %h expected none", out_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", out_pc, e);
        chk("sb_instr", out_instr, mem_word(e));
      end
    end
  end

  initial begin
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_imem_addr", imem_addr, BASE);

    @(posedge clk); #1;
    rst = 1'b0;
    expect_run(BASE, 5);
    @(negedge clk);
    chk("c0_imem_addr", imem_addr, BASE);
    chk("c0_out_valid", 32'(out_valid), 32'd0);

    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #1;
      rst = (c == 30);
      out_ready = !((c >= 12 && c <= 16) || (c >= 20 && c <= 21) || c == 30 ||
                    (c >= 37 && !(c >= 41 && c <= 44)));
      redirect_valid = 1'b0;
      case (c)
        7:  begin redirect_valid = 1'b1; redirect_pc = BASE + 32'h80; expect_run(BASE + 32'h80, 6); end
        21: begin redirect_valid = 1'b1; redirect_pc = BASE + 32'h40; expect_run(BASE + 32'h40, 4); end
        26: begin redirect_valid = 1'b1; redirect_pc = BASE + 32'h20; expect_run(BASE + 32'h20, 2); end
        31: expect_run(BASE, 3);
`ifdef IFETCH_MISALIGN_CHECK_EN
        38: begin redirect_valid = 1'b1; redirect_pc = BASE + 32'h02; end
        41: begin redirect_valid = 1'b1; redirect_pc = BASE + 32'h08; expect_run(BASE + 32'h08, 2); end
`else
        38: begin redirect_valid = 1'b1; redirect_pc = BASE + 32'h42; expect_run(BASE + 32'h40, 4); end
`endif
        default: ;
      endcase
      @(negedge clk);
      case (c)
        2:  chk("c2_out_valid", 32'(out_valid), 32'd0);
        3:  chk("c3_out_valid", 32'(out_valid), 32'd1);
        7:  chk("redir_pop_addr", imem_addr, BASE + 32'h80);
        8:  chk("redir_bubble", 32'(out_valid), 32'd0);
        9:  chk("redir_head", out_pc, BASE + 32'h80);
        13, 14, 15, 16: begin
          chk("stall_imem_addr", imem_addr, BASE + 32'h94);
          chk("stall_head", out_pc, BASE + 32'h8C);
        end
        21: begin
          chk("full_head", out_pc, BASE + 32'h98);
          chk("full_redir_addr", imem_addr, BASE + 32'h40);
        end
        22: chk("full_bubble", 32'(out_valid), 32'd0);
        23: chk("full_new_head", out_pc, BASE + 32'h40);
        31: begin
          chk("rst2_out_valid", 32'(out_valid), 32'd0);
          chk("rst2_out_pc", out_pc, 32'd0);
          chk("rst2_out_instr", out_instr, 32'd0);
          chk("rst2_imem_addr", imem_addr, BASE);
        end
        33: chk("rst2_c2_valid", 32'(out_valid), 32'd0);
        34: chk("rst2_c3_valid", 32'(out_valid), 32'd1);
`ifdef IFETCH_MISALIGN_CHECK_EN
        39, 40: begin
          chk("fault_set", 32'(fault), 32'd1);
          chk("fault_empty", 32'(out_valid), 32'd0);
        end
        42: begin
          chk("fault_clear", 32'(fault), 32'd0);
          chk("fault_bubble", 32'(out_valid), 32'd0);
        end
        43: chk("fault_recover_head", out_pc, BASE + 32'h08);
`else
        38: chk("align_force_addr", imem_addr, BASE + 32'h40);
        40: chk("align_force_head", out_pc, BASE + 32'h40);
`endif
        default: ;
      endcase
    end

    chk("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
